// File: rtl/frame_mem_pkg.sv
// ============================================================================
// Module      : frame_mem_pkg
// Description : Shared requester ids, default widths and request type for
//               the frame-memory arbiter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package frame_mem_pkg;

  localparam logic [1:0] REQ_VGA  = 2'd0;
  localparam logic [1:0] REQ_DRAW = 2'd1;
  localparam logic [1:0] REQ_CPU  = 2'd2;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;
  localparam int NUM_REQ    = 3;
  localparam int PERF_W     = 16;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin selector with a 1-bit last-winner pointer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  // High when requester b was the most recent winner
  logic last_b;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (en) begin
      if (req_a && req_b) begin
        gnt_a = last_b;
        gnt_b = ~last_b;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b <= 1'b1;
    end else if (gnt_a) begin
      last_b <= 1'b0;
    end else if (gnt_b) begin
      last_b <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/frame_mem_arbiter.sv
// ============================================================================
// Module      : frame_mem_arbiter
// Description : Three-requester single-port frame-memory arbiter (VGA fixed
//               priority, draw/CPU round-robin) with a 2-stage read return.
//               Optional wait counters: FRAME_MEM_ARB_PERF_CNT_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module frame_mem_arbiter
  import frame_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  Clk,
  input  logic                  Reset_n,

  input  logic                  req_0,
  input  logic                  we_0,
  input  logic [ADDR_W-1:0]     addr_0,
  input  logic [DATA_W-1:0]     wdata_0,
  output logic                  gnt_0,

  input  logic                  req_1,
  input  logic                  we_1,
  input  logic [ADDR_W-1:0]     addr_1,
  input  logic [DATA_W-1:0]     wdata_1,
  output logic                  gnt_1,

  input  logic                  req_2,
  input  logic                  we_2,
  input  logic [ADDR_W-1:0]     addr_2,
  input  logic [DATA_W-1:0]     wdata_2,
  output logic                  gnt_2,

  output logic [DATA_W-1:0]     rdata,
  output logic                  rvalid,
  output logic [1:0]            rid,

  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,

  input  logic                  perf_clr,
  output logic [2:0][PERF_W-1:0] perf_wait
);

  logic              rr_en;
  logic              grant_any;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        sel_id;
  logic              iss_vld;
  logic [1:0]        iss_id;

  assign gnt_0 = Reset_n & req_0;
  assign rr_en = Reset_n & ~req_0;

  rr_arb2 u_rr_arb2 (
    .clk   (Clk),
    .rst_n (Reset_n),
    .en    (rr_en),
    .req_a (req_1),
    .req_b (req_2),
    .gnt_a (gnt_1),
    .gnt_b (gnt_2)
  );

  assign grant_any = gnt_0 | gnt_1 | gnt_2;

  always_comb begin
    sel_we    = we_0;
    sel_addr  = addr_0;
    sel_wdata = wdata_0;
    sel_id    = REQ_VGA;
    if (gnt_1) begin
      sel_we    = we_1;
      sel_addr  = addr_1;
      sel_wdata = wdata_1;
      sel_id    = REQ_DRAW;
    end else if (gnt_2) begin
      sel_we    = we_2;
      sel_addr  = addr_2;
      sel_wdata = wdata_2;
      sel_id    = REQ_CPU;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= grant_any;
      mem_we <= grant_any & sel_we;
      if (grant_any) begin
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
    end
  end

  // Issue stage tracks the RAM access cycle; return stage lines up with mem_rdata
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      iss_vld <= 1'b0;
      iss_id  <= 2'd0;
      rvalid  <= 1'b0;
      rid     <= 2'd0;
    end else begin
      iss_vld <= grant_any & ~sel_we;
      iss_id  <= sel_id;
      rvalid  <= iss_vld;
      rid     <= iss_id;
    end
  end

  assign rdata = rvalid ? mem_rdata : '0;

`ifdef FRAME_MEM_ARB_PERF_CNT_EN
  logic [2:0] req_vec;
  logic [2:0] gnt_vec;

  assign req_vec = {req_2, req_1, req_0};
  assign gnt_vec = {gnt_2, gnt_1, gnt_0};

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_perf
    logic [PERF_W-1:0] cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        cnt <= '0;
      end else if (perf_clr) begin
        cnt <= '0;
      end else if (req_vec[r] && !gnt_vec[r] && (cnt != {PERF_W{1'b1}})) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign perf_wait[r] = cnt;
  end
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign perf_wait       = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_frame_mem_arbiter.sv
// ============================================================================
// Module      : tb_frame_mem_arbiter
// Description : Self-checking bench for frame_mem_arbiter with a RAM model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_frame_mem_arbiter;
  import frame_mem_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
`ifdef FRAME_MEM_ARB_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic          Clk     = 1'b0;
  logic          Reset_n = 1'b0;
  logic          req   [3];
  logic          we    [3];
  logic [AW-1:0] addr  [3];
  logic [DW-1:0] wdata [3];
  logic          gnt_0, gnt_1, gnt_2;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic [1:0]    rid;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          perf_clr = 1'b0;
  logic [2:0][15:0] perf_wait;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DW-1:0] shadow [256];
  logic [DW-1:0] ram    [256];

  typedef struct { int due; int id; logic [DW-1:0] data; } rd_exp_t;
  rd_exp_t rq[$];

  always #5 Clk = ~Clk;

  frame_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .req_0(req[0]), .we_0(we[0]), .addr_0(addr[0]), .wdata_0(wdata[0]), .gnt_0(gnt_0),
    .req_1(req[1]), .we_1(we[1]), .addr_1(addr[1]), .wdata_1(wdata[1]), .gnt_1(gnt_1),
    .req_2(req[2]), .we_2(we[2]), .addr_2(addr[2]), .wdata_2(wdata[2]), .gnt_2(gnt_2),
    .rdata(rdata), .rvalid(rvalid), .rid(rid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .perf_clr(perf_clr), .perf_wait(perf_wait)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 16) return 32'hCAFE_F00D;
    return 32'hA5A5_0000 + 32'(a * 7919);
  endfunction

  // Single-port RAM, 1-cycle read latency; preloaded while reset is held
  always @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic clear_reqs();
    for (int r = 0; r < 3; r++) begin
      req[r] = 1'b0; we[r] = 1'b0; addr[r] = '0; wdata[r] = '0;
    end
    perf_clr = 1'b0;
  endtask

  task automatic apply_reset();
    clear_reqs();
    Reset_n = 1'b0;
    tick();
    tick();
    Reset_n = 1'b1;
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    rq.delete();
  endtask

  task automatic test_reset();
    for (int r = 0; r < 3; r++) req[r] = 1'b1;
    @(negedge Clk);
    checks++;
    if ({gnt_2, gnt_1, gnt_0} !== 3'b000) begin
      errors++; $display("FAIL reset_gnt: got %b expected 000", {gnt_2, gnt_1, gnt_0});
    end
    checks++;
    if ({mem_en, mem_we, rvalid, rid, rdata} !== '0) begin
      errors++; $display("FAIL reset_outs: got en=%b we=%b rv=%b rid=%0d rdata=%h expected all 0",
                         mem_en, mem_we, rvalid, rid, rdata);
    end
    checks++;
    if (perf_wait !== '0) begin
      errors++; $display("FAIL reset_perf: got %h expected 0", perf_wait);
    end
    apply_reset();
  endtask

  task automatic test_all_three();
    for (int r = 0; r < 3; r++) begin
      req[r] = 1'b1; we[r] = 1'b0; addr[r] = 16'h0010 + AW'(r);
    end
    @(negedge Clk);
    checks++;
    if ({gnt_2, gnt_1, gnt_0} !== 3'b001) begin
      errors++; $display("FAIL all3_gnt: got %b expected 001", {gnt_2, gnt_1, gnt_0});
    end
    tick();
    clear_reqs();
    @(negedge Clk);
    checks++;
    if ({mem_en, mem_we, mem_addr, rvalid} !== {1'b1, 1'b0, 16'h0010, 1'b0}) begin
      errors++; $display("FAIL all3_issue: got en=%b we=%b addr=%h rv=%b expected 1 0 0010 0",
                         mem_en, mem_we, mem_addr, rvalid);
    end
    tick();
    @(negedge Clk);
    checks++;
    if ({rvalid, rid, rdata} !== {1'b1, REQ_VGA, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL all3_ret: got rv=%b rid=%0d rdata=%h expected 1 0 cafef00d",
                         rvalid, rid, rdata);
    end
    tick();
    @(negedge Clk);
    checks++;
    if (rvalid !== 1'b0) begin
      errors++; $display("FAIL all3_single: got rvalid=%b expected 0", rvalid);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g;
    int         eid;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0020;
        req[2] = 1'b1; we[2] = 1'b0; addr[2] = 16'h0021;
      end else begin
        clear_reqs();
      end
      @(negedge Clk);
      if (i < 4) begin
        exp_g = (i % 2 == 0) ? 3'b010 : 3'b100;
        checks++;
        if ({gnt_2, gnt_1, gnt_0} !== exp_g) begin
          errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, {gnt_2, gnt_1, gnt_0}, exp_g);
        end
      end
      if (i >= 2) begin
        eid = ((i - 2) % 2 == 0) ? 1 : 2;
        checks++;
        if ({rvalid, rid, rdata} !== {1'b1, 2'(eid), init_val(eid == 1 ? 32 : 33)}) begin
          errors++; $display("FAIL rr_ret[%0d]: got rv=%b rid=%0d rdata=%h expected 1 %0d %h",
                             i, rvalid, rid, rdata, eid, init_val(eid == 1 ? 32 : 33));
        end
      end
      tick();
    end
  endtask

  task automatic test_write_then_read();
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 16'h00FF; wdata[2] = 32'h1234_5678;
    @(negedge Clk);
    checks++;
    if ({gnt_2, gnt_1, gnt_0} !== 3'b100) begin
      errors++; $display("FAIL wr_gnt: got %b expected 100", {gnt_2, gnt_1, gnt_0});
    end
    tick();
    clear_reqs();
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h00FF;
    @(negedge Clk);
    checks++;
    if ({gnt_2, gnt_1, gnt_0, mem_en, mem_we, mem_addr, mem_wdata} !==
        {3'b010, 1'b1, 1'b1, 16'h00FF, 32'h1234_5678}) begin
      errors++; $display("FAIL wr_issue: got gnt=%b en=%b we=%b addr=%h wd=%h expected 010 1 1 00ff 12345678",
                         {gnt_2, gnt_1, gnt_0}, mem_en, mem_we, mem_addr, mem_wdata);
    end
    tick();
    clear_reqs();
    @(negedge Clk);
    checks++;
    if ({mem_en, mem_we, mem_addr, rvalid} !== {1'b1, 1'b0, 16'h00FF, 1'b0}) begin
      errors++; $display("FAIL rd_issue: got en=%b we=%b addr=%h rv=%b expected 1 0 00ff 0",
                         mem_en, mem_we, mem_addr, rvalid);
    end
    tick();
    @(negedge Clk);
    checks++;
    if ({rvalid, rid, rdata} !== {1'b1, REQ_DRAW, 32'h1234_5678}) begin
      errors++; $display("FAIL wr_rd_ret: got rv=%b rid=%0d rdata=%h expected 1 1 12345678",
                         rvalid, rid, rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0030;
    @(negedge Clk);
    checks++;
    if ({gnt_2, gnt_1, gnt_0} !== 3'b010) begin
      errors++; $display("FAIL rstmid_gnt: got %b expected 010", {gnt_2, gnt_1, gnt_0});
    end
    tick();
    clear_reqs();
    Reset_n = 1'b0;
    req[0]  = 1'b1;
    @(negedge Clk);
    checks++;
    if ({gnt_2, gnt_1, gnt_0, mem_en, mem_we, mem_addr, mem_wdata, rvalid, rid, rdata, perf_wait} !== '0) begin
      errors++; $display("FAIL rstmid_outs: got gnt=%b en=%b we=%b addr=%h wd=%h rv=%b rid=%0d rd=%h perf=%h expected all 0",
                         {gnt_2, gnt_1, gnt_0}, mem_en, mem_we, mem_addr, mem_wdata, rvalid, rid, rdata, perf_wait);
    end
    tick();
    req[0]  = 1'b0;
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      checks++;
      if (rvalid !== 1'b0) begin
        errors++; $display("FAIL rstmid_drop[%0d]: got rvalid=%b expected 0", i, rvalid);
      end
      tick();
    end
  endtask

  task automatic test_vga_priority();
    logic [2:0] exp_g;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0040;
    for (int i = 0; i < 9; i++) begin
      req[0] = (i < 8); we[0] = 1'b0; addr[0] = AW'($urandom_range(255));
      @(negedge Clk);
      exp_g = (i < 8) ? 3'b001 : 3'b010;
      checks++;
      if ({gnt_2, gnt_1, gnt_0} !== exp_g) begin
        errors++; $display("FAIL vga_prio[%0d]: got %b expected %b", i, {gnt_2, gnt_1, gnt_0}, exp_g);
      end
      tick();
    end
    clear_reqs();
    repeat (3) tick();
  endtask

  // Random traffic against a transaction-level model: pending requests,
  // priority/round-robin winner, shadow memory and expected-return queue.
  task automatic test_random(input int n);
    bit            pend [3];
    bit            pv, pw;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    int            last_rr, g;
    int            pc [3];
    logic [2:0]    exp_g;
    apply_reset();
    last_rr = 2; pv = 1'b0; pw = 1'b0; pa = '0; pd = '0;
    for (int r = 0; r < 3; r++) begin pend[r] = 1'b0; pc[r] = 0; end
    for (int i = 0; i < n; i++) begin
      for (int r = 0; r < 3; r++) begin
        if (!pend[r] && (i < n - 4) && ($urandom_range(99) < ((r == 0) ? 25 : 55))) begin
          pend[r]  = 1'b1;
          we[r]    = 1'($urandom_range(1));
          addr[r]  = AW'($urandom_range(31));
          wdata[r] = $urandom;
        end
        req[r] = pend[r];
      end
      perf_clr = ($urandom_range(19) == 0);
      @(negedge Clk);
      if (pend[0])                 g = 0;
      else if (pend[1] && pend[2]) g = (last_rr == 2) ? 1 : 2;
      else if (pend[1])            g = 1;
      else if (pend[2])            g = 2;
      else                         g = -1;
      exp_g = (g < 0) ? 3'b000 : 3'(1 << g);
      checks++;
      if ({gnt_2, gnt_1, gnt_0} !== exp_g) begin
        errors++; $display("FAIL rnd_gnt@%0d: got %b expected %b", i, {gnt_2, gnt_1, gnt_0}, exp_g);
      end
      checks++;
      if ((mem_en !== pv) || (pv && ((mem_we !== pw) || (mem_addr !== pa) || (pw && (mem_wdata !== pd))))) begin
        errors++; $display("FAIL rnd_mem@%0d: got en=%b we=%b addr=%h wd=%h expected %b %b %h %h",
                           i, mem_en, mem_we, mem_addr, mem_wdata, pv, pw, pa, pd);
      end
      checks++;
      if ((rq.size() > 0) && (rq[0].due == cyc)) begin
        if ({rvalid, rid, rdata} !== {1'b1, 2'(rq[0].id), rq[0].data}) begin
          errors++; $display("FAIL rnd_ret@%0d: got rv=%b rid=%0d rdata=%h expected 1 %0d %h",
                             i, rvalid, rid, rdata, rq[0].id, rq[0].data);
        end
        void'(rq.pop_front());
      end else if (rvalid !== 1'b0) begin
        errors++; $display("FAIL rnd_idle@%0d: got rvalid=%b expected 0", i, rvalid);
      end
      for (int r = 0; r < 3; r++) begin
        checks++;
        if (perf_wait[r] !== (PERF_EN ? 16'(pc[r]) : 16'h0)) begin
          errors++; $display("FAIL rnd_perf%0d@%0d: got %0d expected %0d",
                             r, i, perf_wait[r], PERF_EN ? pc[r] : 0);
        end
      end
      pv = (g >= 0);
      if (pv) begin
        pw = we[g]; pa = addr[g]; pd = wdata[g];
        if (pw) shadow[pa[7:0]] = pd;
        else    rq.push_back('{cyc + 2, g, shadow[pa[7:0]]});
        if (g > 0) last_rr = g;
      end
      for (int r = 0; r < 3; r++) begin
        if (perf_clr)                            pc[r] = 0;
        else if (pend[r] && g != r && pc[r] < 65535) pc[r]++;
      end
      if (pv) pend[g] = 1'b0;
      tick();
    end
    clear_reqs();
    repeat (3) tick();
  endtask

`ifdef FRAME_MEM_ARB_PERF_CNT_EN
  task automatic test_perf();
    apply_reset();
    req[0] = 1'b1; addr[0] = 16'h0001;
    req[2] = 1'b1; addr[2] = 16'h0002;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      checks++;
      if (gnt_2 !== 1'b0) begin
        errors++; $display("FAIL perf_block[%0d]: got gnt_2=%b expected 0", i, gnt_2);
      end
      tick();
    end
    req[2] = 1'b0;
    @(negedge Clk);
    checks++;
    if (perf_wait !== {16'd10, 16'd0, 16'd0}) begin
      errors++; $display("FAIL perf_count: got %h expected 000a00000000", perf_wait);
    end
    tick();
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    @(negedge Clk);
    checks++;
    if (perf_wait[2] !== 16'd0) begin
      errors++; $display("FAIL perf_clr: got %0d expected 0", perf_wait[2]);
    end
    req[2]   = 1'b1;
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    @(negedge Clk);
    checks++;
    if (perf_wait[2] !== 16'd0) begin
      errors++; $display("FAIL perf_clr_wins: got %0d expected 0", perf_wait[2]);
    end
    repeat (65534) tick();
    @(negedge Clk);
    checks++;
    if (perf_wait[2] !== 16'hFFFE) begin
      errors++; $display("FAIL perf_near_sat: got %h expected fffe", perf_wait[2]);
    end
    repeat (4) tick();
    @(negedge Clk);
    checks++;
    if (perf_wait[2] !== 16'hFFFF) begin
      errors++; $display("FAIL perf_sat: got %h expected ffff", perf_wait[2]);
    end
    clear_reqs();
    repeat (3) tick();
  endtask
`endif

  initial begin
    clear_reqs();
    #1;
    test_reset();
    test_all_three();
    test_round_robin();
    test_write_then_read();
    test_reset_mid();
    test_vga_priority();
    test_random(400);
`ifdef FRAME_MEM_ARB_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
